external_interrupt_controller: RTL and testbench

EXTERNAL_INTERRUPT_CONTROLLER -- requirements
Module: external_interrupt_controller

---
 rtl/eic_pkg.sv | 18 +
 rtl/eic_gateway.sv | 31 +++
 rtl/external_interrupt_controller.sv | 129 ++++++++++++
 tb/tb_external_interrupt_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eic_pkg.sv
// Shared constants and types for the external interrupt controller.
package eic_pkg;

  localparam int ID_W = 8;

  localparam logic [9:0] OFF_PRIO    = 10'h000;
  localparam logic [9:0] OFF_PENDING = 10'h080;
  localparam logic [9:0] OFF_ENABLE  = 10'h100;
  localparam logic [9:0] OFF_THRESH  = 10'h200;
  localparam logic [9:0] OFF_CLAIM   = 10'h204;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/eic_gateway.sv
// Per-source gateway: latches a level request until it is claimed, then
// blocks the source until the handler completes it.
module eic_gateway
  import eic_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  gw_state_e state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= GW_IDLE;
    end else begin
      case (state_q)
        GW_IDLE:    if (level_i)    state_q <= GW_PENDING;
        GW_PENDING: if (claim_i)    state_q <= GW_CLAIMED;
        GW_CLAIMED: if (complete_i) state_q <= GW_IDLE;
        default:                    state_q <= GW_IDLE;
      endcase
    end
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/external_interrupt_controller.sv
// External interrupt controller: per-source gateways, priority/threshold
// arbitration and a claim/complete register window. Define EIC_INPUT_SYNC_EN
// to double-flop irq_sources before the gateways.
module external_interrupt_controller
  import eic_pkg::*;
#(
  parameter int          NUM_SOURCES    = 7,
  parameter int          PRIORITY_WIDTH = 3,
  parameter logic [31:0] BASE_ADDRESS   = 32'h82000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  input  logic                   write_enable,
  input  logic                   read_enable,
  output logic [31:0]            read_data,
  output logic                   read_valid,
  output logic                   pad_external_interrupt
);

  logic [NUM_SOURCES-1:0]                     level;
  logic [NUM_SOURCES-1:0]                     pending;
  logic [NUM_SOURCES-1:0][PRIORITY_WIDTH-1:0] prio_q;
  logic [NUM_SOURCES-1:0]                     enable_q;
  logic [PRIORITY_WIDTH-1:0]                  thresh_q;
  logic [31:0]                                read_data_q, rdata_d;
  logic                                       read_valid_q, pad_q, pad_d;
  logic [ID_W-1:0]                            winner_id;
  logic [PRIORITY_WIDTH-1:0]                  best_prio;
  logic                                       in_win, rd_fire, wr_fire;
  logic                                       claim_fire, complete_fire;
  logic [9:0]                                 offset;
  logic                                       unused_wdata;

`ifdef EIC_INPUT_SYNC_EN
  logic [NUM_SOURCES-1:0] sync1_q, sync2_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_sources;
      sync2_q <= sync1_q;
    end
  end
  assign level = sync2_q;
`else
  assign level = irq_sources;
`endif

  assign in_win        = (address[31:10] == BASE_ADDRESS[31:10]);
  assign offset        = address[9:0];
  assign rd_fire       = read_enable && in_win;
  // A simultaneous read wins; the write half of the access is dropped.
  assign wr_fire       = write_enable && !read_enable && in_win;
  assign claim_fire    = rd_fire && (offset == OFF_CLAIM);
  assign complete_fire = wr_fire && (offset == OFF_CLAIM);
  assign unused_wdata  = ^write_data;

  generate
    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
      eic_gateway u_gw (
        .clock      (clock),
        .reset      (reset),
        .level_i    (level[g]),
        .claim_i    (claim_fire && (winner_id == ID_W'(g + 1))),
        .complete_i (complete_fire && (write_data[ID_W-1:0] == ID_W'(g + 1))),
        .pending_o  (pending[g])
      );
    end
  endgenerate

  // Strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    winner_id = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (pending[i] && enable_q[i] && (prio_q[i] > thresh_q) && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        winner_id = ID_W'(i + 1);
      end
    end
  end

  assign pad_d = (winner_id != '0);

  always_comb begin
    rdata_d = '0;
    if (in_win) begin
      for (int i = 0; i < NUM_SOURCES; i++)
        if (offset == OFF_PRIO + 10'(4 * (i + 1))) rdata_d = 32'(prio_q[i]);
      case (offset)
        OFF_PENDING: rdata_d = 32'({pending, 1'b0});
        OFF_ENABLE:  rdata_d = 32'({enable_q, 1'b0});
        OFF_THRESH:  rdata_d = 32'(thresh_q);
        OFF_CLAIM:   rdata_d = 32'(winner_id);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q       <= '0;
      enable_q     <= '0;
      thresh_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      pad_q        <= 1'b0;
    end else begin
      read_valid_q <= read_enable;
      pad_q        <= pad_d;
      if (read_enable) read_data_q <= rdata_d;
      if (wr_fire) begin
        for (int i = 0; i < NUM_SOURCES; i++)
          if (offset == OFF_PRIO + 10'(4 * (i + 1))) prio_q[i] <= write_data[PRIORITY_WIDTH-1:0];
        if (offset == OFF_ENABLE) enable_q <= write_data[NUM_SOURCES:1];
        if (offset == OFF_THRESH) thresh_q <= write_data[PRIORITY_WIDTH-1:0];
      end
    end
  end

  assign read_data              = read_data_q;
  assign read_valid             = read_valid_q;
  assign pad_external_interrupt = pad_q;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Self-checking bench for external_interrupt_controller: register vector
// table followed by hand-written gateway/arbitration/reset sequences.
module tb_external_interrupt_controller;

  localparam logic [31:0] B = 32'h82000000;
`ifdef EIC_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  irq = '0;
  logic [31:0] address = '0, write_data = '0;
  logic        write_enable = 1'b0, read_enable = 1'b0;
  logic [31:0] read_data;
  logic        read_valid, pad;

  int n_chk  = 0;
  int n_fail = 0;

  external_interrupt_controller dut (
    .clock                  (clock),
    .reset                  (reset),
    .irq_sources            (irq),
    .address                (address),
    .write_data             (write_data),
    .write_enable           (write_enable),
    .read_enable            (read_enable),
    .read_data              (read_data),
    .read_valid             (read_valid),
    .pad_external_interrupt (pad)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_vld;
    logic        chk_rd;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    read_enable  = re;
    write_enable = we;
    address      = a;
    write_data   = d;
    @(posedge clock);
    #1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    cyc(1'b1, 1'b0, a, 32'h0);
    chk(nm, read_data, e);
    chk({nm, "_vld"}, 32'(read_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic [6:0] m);
    irq = m;
    @(posedge clock);
    #1;
    irq = '0;
    idle(LAT - 1);
  endtask

  function automatic vec_t W(input logic [31:0] a, input logic [31:0] d);
    return '{re: 1'b0, we: 1'b1, addr: a, wd: d, exp_rd: 32'h0, exp_vld: 1'b0, chk_rd: 1'b0};
  endfunction

  function automatic vec_t R(input logic [31:0] a, input logic [31:0] e);
    return '{re: 1'b1, we: 1'b0, addr: a, wd: 32'h0, exp_rd: e, exp_vld: 1'b1, chk_rd: 1'b1};
  endfunction

  initial begin
    tv.push_back(W(B + 32'h004, 32'h5));
    tv.push_back(R(B + 32'h004, 32'h5));
    tv.push_back(W(B + 32'h01C, 32'hFF));
    tv.push_back(R(B + 32'h01C, 32'h7));
    tv.push_back(R(B + 32'h000, 32'h0));
    tv.push_back(R(B + 32'h020, 32'h0));
    tv.push_back(W(B + 32'h100, 32'hFFFF_FFFF));
    tv.push_back(R(B + 32'h100, 32'hFE));
    tv.push_back(W(B + 32'h200, 32'h1F));
    tv.push_back(R(B + 32'h200, 32'h7));
    tv.push_back(R(B + 32'h400, 32'h0));
    tv.push_back(R(32'h0000_0200, 32'h0));
    tv.push_back(W(B + 32'h300, 32'h55));
    tv.push_back(R(B + 32'h300, 32'h0));
    tv.push_back(R(B + 32'h080, 32'h0));
    tv.push_back('{re: 1'b1, we: 1'b1, addr: B + 32'h200, wd: 32'h0, exp_rd: 32'h7, exp_vld: 1'b1, chk_rd: 1'b1});
    tv.push_back(R(B + 32'h200, 32'h7));
    tv.push_back(W(32'h8300_0200, 32'h0));
    tv.push_back(R(B + 32'h200, 32'h7));
    tv.push_back(R(B + 32'h204, 32'h0));
    tv.push_back('{re: 1'b0, we: 1'b0, addr: B, wd: 32'h0, exp_rd: 32'h0, exp_vld: 1'b0, chk_rd: 1'b0});
    tv.push_back(W(B + 32'h200, 32'h0));
    tv.push_back(W(B + 32'h004, 32'h0));
    tv.push_back(W(B + 32'h01C, 32'h0));
    tv.push_back(W(B + 32'h100, 32'h0));
    tv.push_back(R(B + 32'h100, 32'h0));
    tv.push_back(R(B + 32'h200, 32'h0));

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_rvalid", 32'(read_valid), 32'd0);
    chk("rst_pad", 32'(pad), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Register access table
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].re, tv[i].we, tv[i].addr, tv[i].wd);
      chk($sformatf("tv%0d_vld", i), 32'(read_valid), 32'(tv[i].exp_vld));
      chk($sformatf("tv%0d_pad", i), 32'(pad), 32'd0);
      if (tv[i].chk_rd) chk($sformatf("tv%0d_rdata", i), read_data, tv[i].exp_rd);
    end

    // Single pulse on source 3: pad rises after gateway + pad register
    wr(B + 32'h00C, 32'h2);
    wr(B + 32'h100, 32'h08);
    irq = 7'b0000100;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clock);
      #1;
      irq = '0;
      chk($sformatf("s1_pad_e%0d", k), 32'(pad), 32'(k == LAT + 1));
    end
    rd(B + 32'h080, 32'h08, "s1_pend");
    rd(B + 32'h204, 32'h3, "s1_claim");
    chk("s1_pad_claim_edge", 32'(pad), 32'd1);
    idle(1);
    chk("s1_pad_fall", 32'(pad), 32'd0);
    rd(B + 32'h080, 32'h0, "s1_pend_claimed");
    wr(B + 32'h204, 32'h3);
    rd(B + 32'h204, 32'h0, "s1_claim_empty");

    // Equal priorities: lowest ID first, then the other, then none
    wr(B + 32'h008, 32'h4);
    wr(B + 32'h014, 32'h4);
    wr(B + 32'h100, 32'h24);
    pulse(7'b0010010);
    rd(B + 32'h204, 32'h2, "s2_claim_a");
    rd(B + 32'h204, 32'h5, "s2_claim_b");
    rd(B + 32'h204, 32'h0, "s2_claim_c");
    chk("s2_pad_none", 32'(pad), 32'd0);
    wr(B + 32'h204, 32'h5);
    wr(B + 32'h204, 32'h2);
    rd(B + 32'h080, 32'h0, "s2_pend_done");

    // Threshold gating
    wr(B + 32'h200, 32'h4);
    wr(B + 32'h004, 32'h4);
    wr(B + 32'h100, 32'h02);
    pulse(7'b0000001);
    idle(2);
    chk("s3_pad_gated", 32'(pad), 32'd0);
    rd(B + 32'h204, 32'h0, "s3_claim_gated");
    rd(B + 32'h080, 32'h2, "s3_pend_kept");
    wr(B + 32'h200, 32'h3);
    chk("s3_pad_thr_edge", 32'(pad), 32'd0);
    idle(1);
    chk("s3_pad_rise", 32'(pad), 32'd1);
    rd(B + 32'h204, 32'h1, "s3_claim");
    wr(B + 32'h204, 32'h1);
    wr(B + 32'h200, 32'h0);

    // Held level: blocked while claimed, re-pends one cycle after complete
    wr(B + 32'h018, 32'h3);
    wr(B + 32'h100, 32'h40);
    irq = 7'b0100000;
    idle(LAT + 1);
    chk("s4_pad_rise", 32'(pad), 32'd1);
    rd(B + 32'h204, 32'h6, "s4_claim");
    idle(2);
    rd(B + 32'h080, 32'h0, "s4_pend_claimed");
    chk("s4_pad_claimed", 32'(pad), 32'd0);
    wr(B + 32'h204, 32'h9);
    wr(B + 32'h204, 32'h0);
    rd(B + 32'h080, 32'h0, "s4_pend_bad_cmpl");
    wr(B + 32'h204, 32'h6);
    rd(B + 32'h080, 32'h0, "s4_pend_c1");
    rd(B + 32'h080, 32'h40, "s4_pend_c2");
    chk("s4_pad_repend", 32'(pad), 32'd1);
    irq = '0;
    rd(B + 32'h204, 32'h6, "s4_claim2");
    wr(B + 32'h204, 32'h6);
    idle(LAT + 1);
    rd(B + 32'h080, 32'h0, "s4_pend_final");
    wr(B + 32'h100, 32'h0);

    // Pending bitmap with sources 1 and 3
    pulse(7'b0000101);
    rd(B + 32'h080, 32'h0A, "s5_pend");
    idle(1);
    chk("s5_vld_drop", 32'(read_valid), 32'd0);

    // Reset while source 4 is claimed
    wr(B + 32'h010, 32'h2);
    wr(B + 32'h004, 32'h1);
    wr(B + 32'h100, 32'h12);
    pulse(7'b0001000);
    idle(1);
    chk("s6_pad_pre", 32'(pad), 32'd1);
    rd(B + 32'h204, 32'h4, "s6_claim");
    chk("s6_pad_claim", 32'(pad), 32'd1);
    reset = 1'b1;
    #1;
    chk("s6_rst_rdata", read_data, 32'h0);
    chk("s6_rst_vld", 32'(read_valid), 32'd0);
    chk("s6_rst_pad", 32'(pad), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rd(B + 32'h080, 32'h0, "s6_pend_post");
    rd(B + 32'h010, 32'h0, "s6_prio_post");
    rd(B + 32'h100, 32'h0, "s6_en_post");
    rd(B + 32'h204, 32'h0, "s6_claim_post");
    chk("s6_pad_post", 32'(pad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
